pll_cfg_master: RTL

Wishbone-classic initiator that drives the dynamic-configuration port of the on-chip EHXPLLJ PLL (PLLSTB/PLLWE/PLLADDR/PLLDATI, response PLLDATO/PLLACK). It accepts single read, write or masked read-modify-write commands from a local controller (e.g. the SPI slave register bank) and sequences them onto the PLL bus. It also optionally pulses PLLRST after a write and waits for LOCK. It sits beside the PLL wrapper and shares the PLL configuration clock.

---
 rtl/pll_cfg_pkg.sv | 29 ++
 rtl/pll_cfg_timeout.sv | 24 ++
 rtl/pll_cfg_master.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared types and constants for the PLL dynamic-configuration bus master.
package pll_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_MERGE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RST_PULSE,
    ST_LOCK_WAIT,
    ST_RESP
  } state_t;

  localparam logic [4:0] ADDR_CLKI_DIV  = 5'h00;
  localparam logic [4:0] ADDR_CLKFB_DIV = 5'h01;
  localparam logic [4:0] ADDR_CLKOP_DIV = 5'h02;
  localparam logic [4:0] ADDR_TRIM      = 5'h04;

  localparam logic [7:0] FULL_MASK = 8'hFF;

  function automatic logic [7:0] merge_bits(input logic [7:0] rd,
                                            input logic [7:0] wd,
                                            input logic [7:0] mask);
    return (rd & ~mask) | (wd & mask);
  endfunction

endpackage

// File: rtl/pll_cfg_timeout.sv
// Loadable down-counter that saturates at zero; expired while the count is zero.
module pll_cfg_timeout (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_expired = (r_cnt == 8'd0);

endmodule

// File: rtl/pll_cfg_master.sv
// Sequences single read / write / masked RMW commands onto the EHXPLLJ
// configuration bus, with optional PLLRST pulse and LOCK wait after a write.
module pll_cfg_master
  import pll_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned RST_CYC     = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WE,
  input  logic [4:0] CMD_ADDR,
  input  logic [7:0] CMD_WDATA,
  input  logic [7:0] CMD_MASK,
  input  logic       CMD_RST,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       RSP_ERR,
  output logic       PLLSTB,
  output logic       PLLWE,
  output logic [4:0] PLLADDR,
  output logic [7:0] PLLDATI,
  input  logic [7:0] PLLDATO,
  input  logic       PLLACK,
  output logic       PLLRST,
  input  logic       LOCK
);

  // The timer counts down from N-1 so a wait window spans exactly N cycles.
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYC - 1);
  localparam logic [7:0] RST_LOAD = 8'(RST_CYC - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_tmr_load;
  logic [7:0] w_tmr_val;
  logic       w_expired;
  logic       w_cap;
  logic       w_tmo;
  logic       w_accept;

  logic       r_we;
  logic       r_rst;
  logic [7:0] r_wdata;
  logic [7:0] r_mask;
  logic [7:0] r_rd;
  logic       r_stb;
  logic       r_plwe;
  logic [4:0] r_addr;
  logic [7:0] r_dati;
  logic       r_pllrst;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;
  logic       r_lock_s1;
  logic       r_lock_s2;

  pll_cfg_timeout u_timer (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_expired)
  );

  assign w_accept = (r_state == ST_IDLE) && CMD_VALID;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = TMO_LOAD;
    w_cap       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (CMD_VALID) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = (!CMD_WE || CMD_MASK != FULL_MASK) ? ST_RD_REQ : ST_WR_REQ;
        end
      end
      ST_RD_REQ, ST_RD_WAIT: begin
        if (PLLACK) begin
          w_cap       = 1'b1;
          w_state_nxt = r_we ? ST_MERGE : ST_RESP;
        end else if (w_expired) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_MERGE: begin
        w_tmr_load  = 1'b1;
        w_state_nxt = ST_WR_REQ;
      end
      ST_WR_REQ, ST_WR_WAIT: begin
        if (PLLACK) begin
          if (r_rst) begin
            w_tmr_load  = 1'b1;
            w_tmr_val   = RST_LOAD;
            w_state_nxt = ST_RST_PULSE;
          end else begin
            w_state_nxt = ST_RESP;
          end
        end else if (w_expired) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WR_WAIT;
        end
      end
      ST_RST_PULSE: begin
        if (w_expired) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = ST_LOCK_WAIT;
        end
      end
      ST_LOCK_WAIT: begin
        if (r_lock_s2) begin
          w_state_nxt = ST_RESP;
        end else if (w_expired) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they never glitch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stb       <= 1'b0;
      r_plwe      <= 1'b0;
      r_pllrst    <= 1'b0;
      r_addr      <= 5'd0;
      r_dati      <= 8'd0;
      r_we        <= 1'b0;
      r_rst       <= 1'b0;
      r_wdata     <= 8'd0;
      r_mask      <= 8'd0;
      r_rd        <= 8'd0;
      r_rsp_rdata <= 8'd0;
      r_rsp_err   <= 1'b0;
      r_lock_s1   <= 1'b0;
      r_lock_s2   <= 1'b0;
    end else begin
      r_lock_s1 <= LOCK;
      r_lock_s2 <= r_lock_s1;
      r_stb     <= w_state_nxt inside {ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_WR_WAIT};
      r_plwe    <= w_state_nxt inside {ST_WR_REQ, ST_WR_WAIT};
      r_pllrst  <= (w_state_nxt == ST_RST_PULSE);
      if (w_accept) begin
        r_addr  <= CMD_ADDR;
        r_wdata <= CMD_WDATA;
        r_dati  <= CMD_WDATA;
        r_mask  <= CMD_MASK;
        r_we    <= CMD_WE;
        r_rst   <= CMD_RST;
        r_rd    <= 8'd0;
      end
      if (w_cap) r_rd <= PLLDATO;
      if (r_state == ST_MERGE) r_dati <= merge_bits(r_rd, r_wdata, r_mask);
      // Response fields change only on entry to RESP, so they hold between pulses.
      if (w_state_nxt == ST_RESP && r_state != ST_RESP) begin
        r_rsp_err   <= w_tmo;
        r_rsp_rdata <= w_cap ? PLLDATO : r_rd;
      end
    end
  end

  assign CMD_READY = (r_state == ST_IDLE);
  assign RSP_VALID = (r_state == ST_RESP);
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;
  assign PLLSTB    = r_stb;
  assign PLLWE     = r_plwe;
  assign PLLADDR   = r_addr;
  assign PLLDATI   = r_dati;
  assign PLLRST    = r_pllrst;

endmodule
